axis_rr_arb_mux: RTL
====================

// Module: axis_rr_arb_mux
// PURPOSE
// - Frame-aware round-robin arbiter and mux: shares one AXI-Stream output (e.g. the input of a shared axis FIFO)
//   between N_PORTS stream sources. Grant is locked from the first beat of a frame until its tlast beat.
// - Registered output stage; the source index is carried on m_axis_tid so downstream logic can demux.
// PARAMETERS
// - N_PORTS   4                requester count, >=2
// - DATA_W    8                tdata width, bits
// - KEEP_W    (DATA_W+7)/8     tkeep width
// - USR_W     1                tuser width
// - IDX_W     $clog2(N_PORTS)  grant index width (derived; not overridable)
// PORTS
// - clk                 in   1               clock, rising edge
// - srst_n              in   1               reset, synchronous, active-low
// - s_axis_tdata        in   N_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
// - s_axis_tkeep        in   N_PORTS*KEEP_W  per-port tkeep, same packing
// - s_axis_tuser        in   N_PORTS*USR_W   per-port tuser, same packing
// - s_axis_tlast        in   N_PORTS         per-port tlast
// - s_axis_tvalid       in   N_PORTS         per-port tvalid
// - s_axis_tready       out  N_PORTS         per-port tready
// - m_axis_tdata/tkeep/tuser/tlast  out  DATA_W/KEEP_W/USR_W/1   muxed beat, registered
// - m_axis_tid          out  IDX_W           source port index of current beat
// - m_axis_tvalid       out  1               output valid
// - m_axis_tready       in   1               output ready
// - stat_grant          out  IDX_W           currently/last granted port
// - stat_busy           out  1               1 while a frame is in progress
// BEHAVIOUR
// - Reset (srst_n=0 at a clk edge): state IDLE, m_axis_tvalid=0, s_axis_tready=0, stat_busy=0, stat_grant=0,
//   rr pointer last=N_PORTS-1 (so port 0 has first priority). Data outputs hold their values and are don't-care.
// - FSM IDLE: if any s_axis_tvalid[i]=1, pick first i with tvalid=1, searching from (last+1) mod N_PORTS upward with wrap;
//   register grant<=i, goto BUSY. No valid inputs -> stay IDLE. tready=0 for all ports in IDLE.
// - FSM BUSY: s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready; all other tready=0.
//   An accepted beat (tvalid&&tready on grant) loads the output register next clk; m_axis_tid<=grant.
//   An accepted beat with tlast=1: last<=grant, goto IDLE.
// - One IDLE cycle between frames is required; peak throughput is 1 beat/clk within a frame.
// - Output reg: m_axis_tvalid set on load; cleared when m_axis_tready=1 and no new load in the same cycle.
//   Load and drain in the same cycle are allowed (back-to-back beats). Data is stable while tvalid=1 && !tready.
// - Latency: source beat accepted at edge k -> on m_axis at edge k+1.
// - Grant never changes mid-frame, even if the granted source deasserts tvalid (gaps allowed, no timeout).
// - Ports that drop tvalid before grant simply lose that arbitration; no tvalid-stability requirement is assumed of sources.
// - Reset mid-frame: frame truncated, FSM to IDLE, output beat dropped, no tlast emitted.
// - stat_busy = (state==BUSY); stat_grant = grant register.
// CONFIGURATION
// - Macro AXIS_RR_ARB_PAUSE_EN defined: adds ports pause_req (in 1) and pause_ack (out 1).
//   pause_req=1 blocks IDLE->BUSY; a frame in progress completes normally.
//   pause_ack=1 (registered, reset 0) when pause_req=1, state IDLE and m_axis_tvalid=0; drops the cycle after pause_req=0.
// - Macro not defined: no pause ports; arbitration never blocked.
// TESTING
// - Reset, all tvalid=0 for 10 clk -> m_axis_tvalid=0, s_axis_tready=0, stat_busy=0.
// - Ports 0..3 each hold a 3-beat frame valid at once, m_axis_tready=1 -> output order 0,1,2,3, tid matches, 12 beats,
//   each frame contiguous, one idle cycle between frames.
// - Port 1 sends a 4-beat frame with a 2-clk tvalid gap after beat 2; port 2 valid throughout ->
//   port 2 sees tready=0 until port 1 tlast is accepted.
// - m_axis_tready toggled 1010 during an 8-beat frame with data 0x10..0x17 -> exactly 0x10..0x17 in order,
//   no duplicates or drops, data stable while stalled.
// - Fairness: ports 0 and 3 continuously valid with 1-beat frames -> grants alternate 0,3,0,3; last=3 with only port 0
//   valid -> port 0 granted.
// - Reset asserted on beat 2 of a 5-beat frame -> tvalid=0 next clk; a new frame on port 0 then arbitrates normally.
// - AXIS_RR_ARB_PAUSE_EN: pause_req=1 mid-frame -> frame completes, pause_ack=1 after drain, no new grant;
//   pause_req=0 -> next frame granted.

Source files
------------

// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux: frame-aware round-robin arbiter and mux that shares one
// AXI-Stream output among N_PORTS sources. The grant is locked from the first
// beat of a frame until its tlast beat. The output stage is a single register,
// and m_axis_tid carries the source index of each beat.
// Optional feature: define AXIS_RR_ARB_PAUSE_EN to add pause_req/pause_ack.
// With pause_req high, no new frame is granted. A frame already in progress
// runs to completion. pause_ack reports that the block is quiescent.
module axis_rr_arb_mux #(
    parameter  int N_PORTS = 4,
    parameter  int DATA_W  = 8,
    parameter  int KEEP_W  = (DATA_W + 7) / 8,
    parameter  int USR_W   = 1,
    localparam int IDX_W   = $clog2(N_PORTS)
) (
    input  logic                      clk,
    input  logic                      srst_n,
    input  logic [N_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [N_PORTS*KEEP_W-1:0] s_axis_tkeep,
    input  logic [N_PORTS*USR_W-1:0]  s_axis_tuser,
    input  logic [N_PORTS-1:0]        s_axis_tlast,
    input  logic [N_PORTS-1:0]        s_axis_tvalid,
    output logic [N_PORTS-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [KEEP_W-1:0]         m_axis_tkeep,
    output logic [USR_W-1:0]          m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic [IDX_W-1:0]          m_axis_tid,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
`ifdef AXIS_RR_ARB_PAUSE_EN
    input  logic                      pause_req,
    output logic                      pause_ack,
`endif
    output logic [IDX_W-1:0]          stat_grant,
    output logic                      stat_busy
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_q;
    logic               m_tvalid_q;
    logic [DATA_W-1:0]  m_tdata_q;
    logic [KEEP_W-1:0]  m_tkeep_q;
    logic [USR_W-1:0]   m_tuser_q;
    logic               m_tlast_q;
    logic [IDX_W-1:0]   m_tid_q;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               arb_block;
    logic               accept;

    // Per-port views of the packed input buses, so the mux indexes by grant.
    logic [DATA_W-1:0]  s_data [N_PORTS];
    logic [KEEP_W-1:0]  s_keep [N_PORTS];
    logic [USR_W-1:0]   s_user [N_PORTS];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
        assign s_data[g] = s_axis_tdata[g*DATA_W +: DATA_W];
        assign s_keep[g] = s_axis_tkeep[g*KEEP_W +: KEEP_W];
        assign s_user[g] = s_axis_tuser[g*USR_W +: USR_W];
    end

    // Round-robin search starting one past the last served port.
    // The smallest offset from last_q is visited last, so it wins.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = N_PORTS; k >= 1; k--) begin
            cand = (int'(last_q) + k) % N_PORTS;
            if (s_axis_tvalid[IDX_W'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    // Only the granted port may be ready, and only when the output register can take a beat.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_BUSY) begin
            s_axis_tready[grant_q] = !m_tvalid_q || m_axis_tready;
        end
    end

    assign accept = (state_q == ST_BUSY) && s_axis_tvalid[grant_q] && s_axis_tready[grant_q];

`ifdef AXIS_RR_ARB_PAUSE_EN
    logic pause_ack_q;

    assign arb_block = pause_req;
    assign pause_ack = pause_ack_q;

    // Acknowledge the pause once no frame is active and the output register is empty.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            pause_ack_q <= 1'b0;
        end else begin
            pause_ack_q <= pause_req && (state_q == ST_IDLE) && !m_tvalid_q;
        end
    end
`else
    assign arb_block = 1'b0;
`endif

    // Arbitration FSM, round-robin pointer and output-valid flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!srst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(N_PORTS - 1);
            m_tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld && !arb_block) begin
                        grant_q <= pick_idx;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && s_axis_tlast[grant_q]) begin
                        last_q  <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                m_tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    // Output payload register. It loads on every accepted beat and holds otherwise.
    always_ff @(posedge clk) begin
        // NOTE: the payload is not reset; m_axis_tvalid qualifies it, so reset only gates the load.
        if (srst_n && accept) begin
            m_tdata_q <= s_data[grant_q];
            m_tkeep_q <= s_keep[grant_q];
            m_tuser_q <= s_user[grant_q];
            m_tlast_q <= s_axis_tlast[grant_q];
            m_tid_q   <= grant_q;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tid    = m_tid_q;
    assign stat_grant    = grant_q;
    assign stat_busy     = (state_q == ST_BUSY);

endmodule
